// File: rtl/conversor_tempo_seq.sv
// conversor_tempo_seq: sequential seconds-to-calendar decomposer.
// One restoring shift-subtract divider is reused for five cascaded divisions
// (year, month, day, hour, minute). Each division runs on the previous
// remainder, and the final remainder is the seconds field.
// Optional macro: CONVERSOR_TEMPO_DISPLAY_EN prints each result (simulation only).
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   in_valid/in_ready    input handshake; in_seg = seconds to decompose
//   out_valid/out_ready  output handshake; fields held stable while out_valid
//   anos..segundos       result fields, WIDTH bits each, zero-extended
module conversor_tempo_seq #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned SEG_ANO  = 31536000,
  parameter int unsigned SEG_MES  = 2592000,
  parameter int unsigned SEG_DIA  = 86400,
  parameter int unsigned SEG_HORA = 3600,
  parameter int unsigned SEG_MIN  = 60
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_seg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] anos,
  output logic [WIDTH-1:0] meses,
  output logic [WIDTH-1:0] dias,
  output logic [WIDTH-1:0] horas,
  output logic [WIDTH-1:0] minutos,
  output logic [WIDTH-1:0] segundos
);

  localparam int unsigned WP1 = WIDTH + 1;
  localparam int unsigned BW  = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [2:0]       stage_q, stage_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] anos_q, anos_d, meses_q, meses_d, dias_q, dias_d;
  logic [WIDTH-1:0] horas_q, horas_d, minutos_q, minutos_d;
  logic [WIDTH-1:0] segundos_q, segundos_d;

  logic [WIDTH:0]   divisor_c;
  logic [WIDTH:0]   rem_shift_c;
  logic             ge_c;
  logic [WIDTH-1:0] rem_new_c;
  logic [WIDTH-1:0] quo_new_c;

  // Divisor for the current stage
  always_comb begin
    divisor_c = WP1'(SEG_MIN);
    case (stage_q)
      3'd0:    divisor_c = WP1'(SEG_ANO);
      3'd1:    divisor_c = WP1'(SEG_MES);
      3'd2:    divisor_c = WP1'(SEG_DIA);
      3'd3:    divisor_c = WP1'(SEG_HORA);
      default: divisor_c = WP1'(SEG_MIN);
    endcase
  end

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  // The remainder is always below the divisor, so WIDTH bits hold it.
  always_comb begin
    rem_shift_c = {rem_q, dvd_q[WIDTH-1]};
    ge_c        = (rem_shift_c >= divisor_c);
    rem_new_c   = ge_c ? WIDTH'(rem_shift_c - divisor_c) : WIDTH'(rem_shift_c);
    quo_new_c   = quo_q | (WIDTH'(ge_c) << bit_q);
  end

  // Next-state and datapath updates
  always_comb begin
    state_d    = state_q;
    dvd_d      = dvd_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    bit_d      = bit_q;
    stage_d    = stage_q;
    anos_d     = anos_q;
    meses_d    = meses_q;
    dias_d     = dias_q;
    horas_d    = horas_q;
    minutos_d  = minutos_q;
    segundos_d = segundos_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          dvd_d   = in_seg;
          rem_d   = '0;
          quo_d   = '0;
          stage_d = 3'd0;
          bit_d   = BW'(WIDTH - 1);
          state_d = DIV;
        end
      end
      DIV: begin
        dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        rem_d = rem_new_c;
        quo_d = quo_new_c;
        bit_d = bit_q - BW'(1);
        if (bit_q == '0) begin
          case (stage_q)
            3'd0:    anos_d    = quo_new_c;
            3'd1:    meses_d   = quo_new_c;
            3'd2:    dias_d    = quo_new_c;
            3'd3:    horas_d   = quo_new_c;
            default: begin
              minutos_d  = quo_new_c;
              segundos_d = rem_new_c;
            end
          endcase
          // Remainder seeds the next stage's dividend
          dvd_d   = rem_new_c;
          rem_d   = '0;
          quo_d   = '0;
          bit_d   = BW'(WIDTH - 1);
          stage_d = stage_q + 3'd1;
          if (stage_q == 3'd4) state_d = DONE;
        end
      end
      DONE: begin
        if (out_valid_q && out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dvd_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      bit_q       <= '0;
      stage_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      anos_q      <= '0;
      meses_q     <= '0;
      dias_q      <= '0;
      horas_q     <= '0;
      minutos_q   <= '0;
      segundos_q  <= '0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      bit_q       <= bit_d;
      stage_q     <= stage_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      anos_q      <= anos_d;
      meses_q     <= meses_d;
      dias_q      <= dias_d;
      horas_q     <= horas_d;
      minutos_q   <= minutos_d;
      segundos_q  <= segundos_d;
    end
  end

`ifdef CONVERSOR_TEMPO_DISPLAY_EN
  // Report each result as out_valid rises
  always @(posedge clk) begin
    if (rst_n && out_valid_d && !out_valid_q)
      $display("%d anos, %d meses, %d dias, %d horas, %d minutos e %d segundos",
               anos_d, meses_d, dias_d, horas_d, minutos_d, segundos_d);
  end
`else
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign anos      = anos_q;
  assign meses     = meses_q;
  assign dias      = dias_q;
  assign horas     = horas_q;
  assign minutos   = minutos_q;
  assign segundos  = segundos_q;

endmodule

// File: tb/tb_conversor_tempo_seq.sv
// Testbench for conversor_tempo_seq: directed corner values plus random
// seconds counts, checked against a division/modulo reference model.
module tb_conversor_tempo_seq;

  localparam int unsigned W = 32;
  localparam longint unsigned S_ANO  = 31536000;
  localparam longint unsigned S_MES  = 2592000;
  localparam longint unsigned S_DIA  = 86400;
  localparam longint unsigned S_HORA = 3600;
  localparam longint unsigned S_MIN  = 60;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_seg;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] anos, meses, dias, horas, minutos, segundos;

  int n_checks = 0;
  int n_errors = 0;

  conversor_tempo_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_seg   (in_seg),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .anos     (anos),
    .meses    (meses),
    .dias     (dias),
    .horas    (horas),
    .minutos  (minutos),
    .segundos (segundos)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division cascade
  function automatic void model(input longint unsigned s, output longint unsigned f[6]);
    longint unsigned r;
    f[0] = s / S_ANO;  r = s % S_ANO;
    f[1] = r / S_MES;  r = r % S_MES;
    f[2] = r / S_DIA;  r = r % S_DIA;
    f[3] = r / S_HORA; r = r % S_HORA;
    f[4] = r / S_MIN;  f[5] = r % S_MIN;
  endfunction

  task automatic check_fields(input string tag, input longint unsigned s);
    longint unsigned f[6];
    model(s, f);
    check({tag, ".anos"},     64'(anos),     f[0]);
    check({tag, ".meses"},    64'(meses),    f[1]);
    check({tag, ".dias"},     64'(dias),     f[2]);
    check({tag, ".horas"},    64'(horas),    f[3]);
    check({tag, ".minutos"},  64'(minutos),  f[4]);
    check({tag, ".segundos"}, 64'(segundos), f[5]);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_idle", 64'(in_ready), 64'd1);
  endtask

  // Full conversion; hold = cycles with out_ready low in DONE, glitch = in_valid pulse during DIV
  task automatic do_conv(input logic [W-1:0] v, input int hold, input bit glitch);
    int cyc;
    wait_ready();
    in_valid = 1'b1;
    in_seg   = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_seg   = W'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 400) begin
      if (glitch && cyc == 20) begin
        in_valid = 1'b1;
        in_seg   = W'(7);
      end else begin
        in_valid = 1'b0;
      end
      if (cyc == 10) check("in_ready_busy", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    check("latency", 64'(cyc), 64'd160);
    check_fields("result", 64'(v));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check_fields("hold", 64'(v));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_valid", 64'(out_valid), 64'd0);
    check("post_in_ready", 64'(in_ready), 64'd1);
    check_fields("retained", 64'(v));
  endtask

  // Reset asserted partway through a conversion
  task automatic abort_conv(input logic [W-1:0] v);
    wait_ready();
    in_valid = 1'b1;
    in_seg   = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (50) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd0);
    check_fields("abort", 64'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_hold_valid", 64'(out_valid), 64'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_release_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_seg    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check_fields("rst", 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_release_ready", 64'(in_ready), 64'd1);

    do_conv(W'(0), 0, 1'b0);
    do_conv(W'(34218061), 0, 1'b0);
    do_conv(W'(31535999), 10, 1'b0);
    do_conv(W'(64'hFFFF_FFFF), 0, 1'b1);
    abort_conv(W'(123456789));
    do_conv(W'(34218061), 1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      do_conv(W'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    do_conv(W'(59), 0, 1'b0);
    do_conv(W'(31536000), 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
